// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - elastic pipelined Rijndael ShiftRows/InvShiftRows, optional SHIFT_ROWS_BLK_COUNT_EN block counter
module shift_rows_pipe #(
    parameter int NB         = 4,
    parameter int PIPE_DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shiftRow_valid_in,
    output logic              shiftRow_ready_in,
    input  logic              shiftRow_inv_in,
    input  logic [32*NB-1:0]  shiftRow_data_in,
    output logic              shiftRow_valid_out,
    input  logic              shiftRow_ready_out,
    output logic [32*NB-1:0]  shiftRow_data_out,
    output logic [31:0]       shiftRow_blk_count
);

    localparam int DW   = 32 * NB;
    localparam int LAST = PIPE_DEPTH - 1;

    logic [DW-1:0] fwd_data;
    logic [DW-1:0] inv_data;
    logic [DW-1:0] xform_data;

    // Byte routing is fixed at elaboration; only the fwd/inv select is runtime logic.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int S  = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int FS = (c + S) % NB;
            localparam int IS = (c + NB - S) % NB;
            assign fwd_data[DW-1-8*(4*c+r) -: 8] = shiftRow_data_in[DW-1-8*(4*FS+r) -: 8];
            assign inv_data[DW-1-8*(4*c+r) -: 8] = shiftRow_data_in[DW-1-8*(4*IS+r) -: 8];
        end
    end

    assign xform_data = shiftRow_inv_in ? inv_data : fwd_data;

    logic [PIPE_DEPTH-1:0]         v_q;
    logic [PIPE_DEPTH-1:0]         load;
    logic [PIPE_DEPTH-1:0]         up_v;
    logic [PIPE_DEPTH-1:0][DW-1:0] data_q;
    logic [PIPE_DEPTH-1:0][DW-1:0] up_data;
    logic                          full_tail;

    // A stage can load unless it and every stage after it are full while the sink stalls.
    always_comb begin
        load      = '0;
        full_tail = 1'b1;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            full_tail = 1'b1;
            for (int j = i; j < PIPE_DEPTH; j++) begin
                full_tail = full_tail & v_q[j];
            end
            load[i] = shiftRow_ready_out | ~full_tail;
        end
    end

    always_comb begin
        up_v       = '0;
        up_data    = '0;
        up_v[0]    = shiftRow_valid_in;
        up_data[0] = xform_data;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            up_v[i]    = v_q[i-1];
            up_data[i] = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            data_q <= '0;
        end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                if (load[i]) begin
                    v_q[i] <= up_v[i];
                    if (up_v[i]) begin
                        data_q[i] <= up_data[i];
                    end
                end
            end
        end
    end

    assign shiftRow_ready_in  = load[0];
    assign shiftRow_valid_out = v_q[LAST];
    assign shiftRow_data_out  = data_q[LAST];

`ifdef SHIFT_ROWS_BLK_COUNT_EN
    logic [31:0] blk_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count_q <= '0;
        end else if (shiftRow_valid_out && shiftRow_ready_out) begin
            blk_count_q <= blk_count_q + 32'd1;
        end
    end

    assign shiftRow_blk_count = blk_count_q;
`else
    assign shiftRow_blk_count = 32'd0;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - self-checking bench for shift_rows_pipe (NB=4 depth 3, NB=8 depth 1)
module tb_shift_rows_pipe;

`ifdef SHIFT_ROWS_BLK_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         m_valid_in, m_ready_in, m_inv_in, m_valid_out, m_ready_out;
    logic [127:0] m_data_in, m_data_out;
    logic [31:0]  m_blk_count;
    logic         e_valid_in, e_ready_in, e_inv_in, e_valid_out, e_ready_out;
    logic [255:0] e_data_in, e_data_out;
    logic [31:0]  e_blk_count;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int n_out  = 0;
    int first_acc_cyc = -1;
    int first_out_cyc = -1;
    int last_out_cyc  = -1;
    logic [127:0] q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_rows_pipe #(.NB(4), .PIPE_DEPTH(3)) u_dut (
        .clk(clk), .rst(rst),
        .shiftRow_valid_in(m_valid_in), .shiftRow_ready_in(m_ready_in),
        .shiftRow_inv_in(m_inv_in), .shiftRow_data_in(m_data_in),
        .shiftRow_valid_out(m_valid_out), .shiftRow_ready_out(m_ready_out),
        .shiftRow_data_out(m_data_out), .shiftRow_blk_count(m_blk_count)
    );

    shift_rows_pipe #(.NB(8), .PIPE_DEPTH(1)) u_dut8 (
        .clk(clk), .rst(rst),
        .shiftRow_valid_in(e_valid_in), .shiftRow_ready_in(e_ready_in),
        .shiftRow_inv_in(e_inv_in), .shiftRow_data_in(e_data_in),
        .shiftRow_valid_out(e_valid_out), .shiftRow_ready_out(e_ready_out),
        .shiftRow_data_out(e_data_out), .shiftRow_blk_count(e_blk_count)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [255:0] model(input int nb, input logic [255:0] d, input logic inv);
        logic [255:0] o;
        int dw, s, src;
        o  = '0;
        dw = 32 * nb;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                s   = (nb == 8 && r >= 2) ? r + 1 : r;
                src = inv ? (c - s + nb) % nb : (c + s) % nb;
                o[dw-1-8*(4*c+r) -: 8] = d[dw-1-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp,
                        input int max_wait, output bit acc);
        acc        = 1'b0;
        m_valid_in = 1'b1;
        m_data_in  = d;
        m_inv_in   = inv;
        for (int k = 0; k < max_wait && !acc; k++) begin
            @(negedge clk);
            if (m_ready_in) begin
                q.push_back(exp);
                acc = 1'b1;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        m_valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    // Output scoreboard: pop on every output transfer, hold-check while stalled.
    always @(negedge clk) begin
        if (!rst && m_valid_out) begin
            chk("out_has_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                if (m_ready_out) begin
                    chk("out_data", m_data_out, q.pop_front());
                    n_out++;
                    last_out_cyc = cyc;
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                end else begin
                    chk("stall_hold", m_data_out, q[0]);
                end
            end
        end
    end

    initial begin
        bit acc;
        int n_acc, n0;
        logic [127:0] d, bp_d[5];
        logic [255:0] cnt8, fwd8;
        bit bp_acc[5];

        rst = 1'b1;
        m_valid_in = 1'b0; m_inv_in = 1'b0; m_data_in = '0; m_ready_out = 1'b0;
        e_valid_in = 1'b0; e_inv_in = 1'b0; e_data_in = '0; e_ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", m_valid_out, 0);
        chk("rst_data_out", m_data_out, 0);
        chk("rst_blk_count", m_blk_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_in", m_ready_in, 1);
        @(posedge clk); #1;

        // Known vectors, forward and inverse
        m_ready_out = 1'b1;
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 4, acc);
        chk("acc_vec0", acc, 1);
        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 4, acc);
        chk("acc_vec1", acc, 1);
        send(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h00050a0f04090e03080d02070c01060b, 4, acc);
        chk("acc_vec2", acc, 1);
        drain();

        // Burst of 8 with alternating mode from a fresh reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        n_out = 0; first_acc_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            send(d, i[0], model(4, {128'd0, d}, i[0]), 4, acc);
            chk("acc_burst", acc, 1);
        end
        drain();
        chk("burst_count", n_out, 8);
        chk("burst_latency", first_out_cyc - first_acc_cyc, 3);
        chk("burst_no_gaps", last_out_cyc - first_out_cyc, 7);
        chk("burst_blk_count", m_blk_count, CNT_EN ? 32'd8 : 32'd0);

        // Backpressure: 3 accepted, ready_in drops, then all 5 drain in order
        m_ready_out = 1'b0;
        n_acc = 0;
        n0 = n_out;
        for (int i = 0; i < 5; i++) begin
            bp_d[i] = {$urandom, $urandom, $urandom, $urandom};
            send(bp_d[i], ~i[0], model(4, {128'd0, bp_d[i]}, ~i[0]), 2, acc);
            bp_acc[i] = acc;
            if (acc) n_acc++;
        end
        chk("bp_accepted", n_acc, 3);
        @(negedge clk);
        chk("bp_ready_in_low", m_ready_in, 0);
        chk("bp_valid_out_held", m_valid_out, 1);
        @(posedge clk); #1;
        m_ready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!bp_acc[i]) begin
                send(bp_d[i], ~i[0], model(4, {128'd0, bp_d[i]}, ~i[0]), 4, acc);
                chk("bp_resend_acc", acc, 1);
            end
        end
        drain();
        chk("bp_all_out", n_out - n0, 5);

        // Reset with two blocks in flight
        m_ready_out = 1'b0;
        send(128'h0123456789abcdeffedcba9876543210, 1'b0, model(4, {128'd0, 128'h0123456789abcdeffedcba9876543210}, 1'b0), 4, acc);
        send(128'h00112233445566778899aabbccddeeff, 1'b1, model(4, {128'd0, 128'h00112233445566778899aabbccddeeff}, 1'b1), 4, acc);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid_out", m_valid_out, 0);
        chk("mid_rst_data_out", m_data_out, 0);
        chk("mid_rst_blk_count", m_blk_count, 0);
        chk("mid_rst_ready_in", m_ready_in, 1);
        rst = 1'b0;
        q.delete();
        m_ready_out = 1'b1;
        n0 = n_out;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_rst_no_output", n_out - n0, 0);

        // NB=8, depth 1: offsets {0,1,3,4}
        for (int k = 0; k < 32; k++) cnt8[255-8*k -: 8] = k[7:0];
        fwd8 = model(8, cnt8, 1'b0);
        e_valid_in = 1'b1; e_data_in = cnt8; e_inv_in = 1'b0;
        @(negedge clk);
        chk("nb8_ready_in", e_ready_in, 1);
        @(posedge clk); #1;
        e_valid_in = 1'b0;
        chk("nb8_valid_out", e_valid_out, 1);
        chk("nb8_col0", e_data_out[255:224], 32'h00050e13);
        chk("nb8_fwd", e_data_out, fwd8);
        e_valid_in = 1'b1; e_data_in = fwd8; e_inv_in = 1'b1;
        @(posedge clk); #1;
        e_valid_in = 1'b0;
        chk("nb8_inv_roundtrip", e_data_out, cnt8);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised successor to the single-stage ShiftRow block.
- Supports Rijndael block widths of 128, 192 and 256 bits (NB = 4, 6, 8 columns).
- Runtime-selectable forward (ShiftRows) or inverse (InvShiftRows) transform.
- Elastic valid/ready pipeline of configurable depth; sits between SubBytes and MixColumns in the encrypt and decrypt round datapaths.

Parameters:
- NB, 4, number of state columns; legal values 4, 6, 8. Data width DW = 32*NB.
- PIPE_DEPTH, 1, number of register stages; legal values 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- shiftRow_valid_in  in  1  input block valid
- shiftRow_ready_in  out  1  block can accept input this cycle
- shiftRow_inv_in  in  1  0 = forward ShiftRows, 1 = InvShiftRows; sampled with the data
- shiftRow_data_in  in  DW  input state
- shiftRow_valid_out  out  1  output block valid
- shiftRow_ready_out  in  1  downstream accepts output
- shiftRow_data_out  out  DW  transformed state
- shiftRow_blk_count  out  32  count of blocks delivered (see Optional Feature)

Behaviour:
- Byte layout:
  - byte k occupies bits [DW-1-8k : DW-8-8k], so byte 0 is the MSB byte.
  - state[r][c] = byte 4c+r (column-major).
- Row offsets:
  - NB = 4 or 6: s = {0,1,2,3}.
  - NB = 8: s = {0,1,3,4}.
- Transform:
  - forward: out[r][c] = in[r][(c+s_r) mod NB].
  - inverse: out[r][c] = in[r][(c-s_r) mod NB].
  - Purely combinational on the input side; the result is captured into stage 0.
- Pipeline:
  - Stages 0..PIPE_DEPTH-1, each holding a data register and a valid bit v[i].
  - The last stage drives the outputs.
  - Stage i loads when !v[i] || (v[i] && downstream of i takes its data this cycle). Downstream of the last stage is shiftRow_ready_out.
  - shiftRow_ready_in = load condition of stage 0.
  - Bubbles collapse: an empty stage is always fillable.
- Handshake rules:
  - Transfer occurs on a clock edge where valid && ready are both high.
  - shiftRow_data_out and shiftRow_valid_out hold stable while shiftRow_valid_out=1 and shiftRow_ready_out=0.
  - shiftRow_valid_in=0 never alters stored data.
  - Data registers of empty stages are don't-care; they are zeroed only on reset.
- Latency and throughput:
  - With shiftRow_ready_out held high, a block accepted at edge N appears with shiftRow_valid_out=1 after edge N+PIPE_DEPTH-1, i.e. PIPE_DEPTH cycles of register delay.
  - Throughput is 1 block/cycle.
- Backpressure:
  - A full pipeline with shiftRow_ready_out=0 drives shiftRow_ready_in=0.
  - When ready_out rises, one block drains per cycle and ready_in rises in the same cycle (combinational path).
- Simultaneous events: with the last stage full and ready_out=1, a new block may enter stage 0 on the same edge; there is no throughput loss.
- Mode switching: shiftRow_inv_in may change every block. Mode is applied at entry, so in-flight blocks are unaffected.
- Reset:
  - On rst=1 at a clock edge, all v[i], shiftRow_valid_out, data registers and shiftRow_blk_count clear to 0.
  - shiftRow_ready_in = 1 in the first cycle after reset deasserts.
  - In-flight blocks are discarded when reset is asserted mid-operation.
  - No output glitch to a stale valid.

Optional Feature:
- Macro: SHIFT_ROWS_BLK_COUNT_EN.
- Defined: shiftRow_blk_count increments by 1 on each output transfer (valid_out && ready_out). It wraps from 0xFFFFFFFF to 0 and clears on rst.
- Undefined: shiftRow_blk_count is tied to 0 and no counter logic is generated.

Test Plan:
- NB=4, PIPE_DEPTH=1, forward: in d42711aee0bf98f1b8b45de51e415230 -> out d4bf5d30e0b452aeb84111f11e2798e5 one cycle later, valid_out=1.
- NB=4, inverse: in d4bf5d30e0b452aeb84111f11e2798e5 -> out d42711aee0bf98f1b8b45de51e415230.
- NB=4, forward: in 000102030405060708090a0b0c0d0e0f -> out 00050a0f04090e03080d02070c01060b. NB=8, forward: in bytes 00..1f -> first output column 00050e13. The NB=8 case exercises the {0,1,3,4} offsets.
- PIPE_DEPTH=3, 8 back-to-back blocks with alternating inv_in, ready_out=1:
  - outputs in order, first valid_out 3 cycles after first accept, no gaps;
  - with SHIFT_ROWS_BLK_COUNT_EN defined, blk_count=8 at the end.
- PIPE_DEPTH=3 backpressure: hold ready_out=0 and drive 5 blocks.
  - Exactly 3 are accepted and ready_in drops to 0.
  - data_out stays stable throughout.
  - Release ready_out: all 5 blocks emerge in order.
- Reset mid-stream: assert rst with 2 blocks in flight -> next cycle valid_out=0, data_out=0, blk_count=0, ready_in=1; neither block ever appears.
